// File: rtl/o_buffer_pkg.sv
// Shared types and constants for the output-buffer drain path.
// FSM encoding and skid FIFO depth used by o_buffer_reader and obr_skid_fifo.
package o_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } obr_state_e;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/o_buffer_reader_if.sv
// Valid/ready result stream leaving the output-buffer reader.
// master drives data/valid/last, slave drives ready.
interface o_buffer_reader_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic signed [DATA_WIDTH-1:0] m_data;
    logic                         m_valid;
    logic                         m_ready;
    logic                         m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/obr_skid_fifo.sv
// Two-entry FIFO holding returned buffer words until the stream accepts them.
// Caller guarantees no push when full and no pop when empty.
module obr_skid_fifo
    import o_buffer_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic [FIFO_CNT_W-1:0] count
);

    typedef logic [FIFO_PTR_W-1:0] ptr_t;

    logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
    ptr_t                  wr_ptr_q;
    ptr_t                  rd_ptr_q;
    logic [FIFO_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            cnt_q <= cnt_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = cnt_q;

endmodule

// File: rtl/o_buffer_reader.sv
// Drains rows of the column-RAM output buffer into a valid/ready stream.
// Define O_BUFFER_READER_RELU_EN to clamp negative words to zero.
module o_buffer_reader
    import o_buffer_pkg::*;
#(
    parameter int RAM_SIZE   = 1 << 8,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int ARRAY_M    = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [ADDR_WIDTH:0]          num_rows,
    input  logic [$clog2(ARRAY_M):0]     num_cols,
    output logic [$clog2(ARRAY_M)-1:0]   ram_idx,
    output logic [ADDR_WIDTH-1:0]        read_addr,
    input  logic signed [DATA_WIDTH-1:0] data_read,
    o_buffer_reader_if.master            strm,
    output logic                         busy,
    output logic                         done
);

    localparam int CW = $clog2(ARRAY_M);
    localparam int NW = CW + 1;
    localparam int FW = DATA_WIDTH + 1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [ADDR_WIDTH:0]   row_t;
    typedef logic [CW-1:0]         col_t;
    typedef logic [NW-1:0]         ncol_t;
    typedef logic [FIFO_CNT_W:0]   crd_t;

    obr_state_e state_q;
    obr_state_e state_d;
    logic       done_d;

    addr_t addr_q;
    addr_t addr_nxt;
    row_t  rows_q;
    row_t  row_q;
    ncol_t cols_q;
    ncol_t cols_in;
    col_t  col_q;

    logic pend_q;
    logic pend_last_q;
    logic done_q;

    logic [FIFO_CNT_W-1:0] fifo_cnt;
    logic [FW-1:0]         head;
    logic signed [DATA_WIDTH-1:0] word;
    crd_t credit;

    logic empty_req;
    logic accept;
    logic last_col;
    logic last_row;
    logic last_issue;
    logic issue;
    logic valid;
    logic pop;
    logic head_last;

    assign cols_in   = (num_cols > ncol_t'(ARRAY_M)) ? ncol_t'(ARRAY_M)
                                                     : num_cols;
    assign empty_req = (num_rows == '0) || (cols_in == '0);
    assign accept    = (state_q == IDLE) && start;

    assign last_col   = ({1'b0, col_q} == cols_q - ncol_t'(1));
    assign last_row   = (row_q == rows_q - row_t'(1));
    assign last_issue = last_col && last_row;

    assign valid     = (fifo_cnt != '0);
    assign pop       = valid && strm.m_ready;
    assign head_last = head[DATA_WIDTH];

    // Reserve a FIFO slot for every read whose data has not landed yet.
    assign credit = crd_t'(fifo_cnt) + crd_t'(pend_q) - crd_t'(pop);
    assign issue  = (state_q == ISSUE) && (credit < crd_t'(FIFO_DEPTH));

    assign addr_nxt = (addr_q == addr_t'(RAM_SIZE - 1)) ? '0
                                                        : addr_q + addr_t'(1);

`ifdef O_BUFFER_READER_RELU_EN
    assign word = data_read[DATA_WIDTH-1] ? '0 : data_read;
`else
    assign word = data_read;
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (empty_req) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue && last_issue) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (pop && head_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pend_q      <= issue;
            pend_last_q <= issue && last_issue;
            done_q      <= done_d;
            if (accept) begin
                addr_q <= base_addr;
                rows_q <= num_rows;
                cols_q <= cols_in;
                row_q  <= '0;
                col_q  <= '0;
            end else if (issue) begin
                if (last_col) begin
                    col_q  <= '0;
                    row_q  <= row_q + row_t'(1);
                    addr_q <= addr_nxt;
                end else begin
                    col_q <= col_q + col_t'(1);
                end
            end
        end
    end

    obr_skid_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pend_q),
        .push_data ({pend_last_q, word}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_cnt)
    );

    assign ram_idx   = issue ? col_q : '0;
    assign read_addr = issue ? addr_q : '0;

    assign strm.m_valid = valid;
    assign strm.m_data  = head[DATA_WIDTH-1:0];
    assign strm.m_last  = valid && head_last;

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_o_buffer_reader.sv
// Scoreboard bench for o_buffer_reader with a registered column-RAM model.
// Expected words follow O_BUFFER_READER_RELU_EN when it is defined.
module tb_o_buffer_reader;

    localparam int RAM_SIZE = 256;
    localparam int AW       = 8;
    localparam int M        = 8;
    localparam int DW       = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [AW:0]          num_rows;
    logic [3:0]           num_cols;
    logic [2:0]           ram_idx;
    logic [AW-1:0]        read_addr;
    logic signed [DW-1:0] data_read;
    logic                 busy;
    logic                 done;

    o_buffer_reader_if #(.DATA_WIDTH(DW)) strm ();

    o_buffer_reader #(
        .RAM_SIZE   (RAM_SIZE),
        .ADDR_WIDTH (AW),
        .ARRAY_M    (M),
        .DATA_WIDTH (DW)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .num_cols  (num_cols),
        .ram_idx   (ram_idx),
        .read_addr (read_addr),
        .data_read (data_read),
        .strm      (strm),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] mem [M][RAM_SIZE];

    always @(posedge clk) data_read <= mem[ram_idx][read_addr];

    typedef struct packed {
        logic                 last;
        logic signed [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   beats = 0;
    bit   stall_prev = 1'b0;
    logic signed [DW-1:0] prev_data;
    logic prev_last;

    task automatic check(input string tag,
                         input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic signed [DW-1:0] model(int c, int a);
        logic signed [DW-1:0] v;
        v = mem[c][a];
`ifdef O_BUFFER_READER_RELU_EN
        if (v < 0) v = '0;
`endif
        return v;
    endfunction

    task automatic push_expected(input int base, input int rows,
                                 input int cols);
        int   cc;
        exp_t x;
        cc = (cols > M) ? M : cols;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cc; c++) begin
                x.last = (r == rows - 1) && (c == cc - 1);
                x.data = model(c, (base + r) % RAM_SIZE);
                sb.push_back(x);
            end
        end
    endtask

    task automatic drive_start(input int base, input int rows,
                               input int cols);
        @(posedge clk);
        #1;
        base_addr = AW'(base);
        num_rows  = (AW + 1)'(rows);
        num_cols  = 4'(cols);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycle i is the i-th cycle after the edge that sampled start.
    task automatic run_to_done(input int budget, input bit toggle,
                               output int cyc, output int first_v);
        cyc     = 0;
        first_v = 0;
        for (int i = 1; i <= budget; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            if (toggle) strm.m_ready = (i % 4 == 1) || (i % 4 == 0);
            @(negedge clk);
            if (strm.m_valid && first_v == 0) first_v = i;
            if (done) begin
                cyc = i;
                break;
            end
        end
        check("done_seen", cyc != 0, 1);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
            beats      = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", strm.m_valid, 1);
                check("stall_data", strm.m_data, prev_data);
                check("stall_last", strm.m_last, prev_last);
            end
            if (strm.m_valid && strm.m_ready) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("beat_data", strm.m_data, e.data);
                    check("beat_last", strm.m_last, e.last);
                end
                beats++;
            end
            stall_prev = strm.m_valid && !strm.m_ready;
            prev_data  = strm.m_data;
            prev_last  = strm.m_last;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, strm.m_valid, 0);
        check({tag, "_last"}, strm.m_last, 0);
        check({tag, "_data"}, strm.m_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ram_idx"}, ram_idx, 0);
        check({tag, "_read_addr"}, read_addr, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int fv;
        int b0;

        for (int c = 0; c < M; c++) begin
            for (int a = 0; a < RAM_SIZE; a++) begin
                mem[c][a] = DW'(1000 + a * 16 + c);
            end
        end
        reset        = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        num_rows     = '0;
        num_cols     = '0;
        strm.m_ready = 1'b1;
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Two full rows at full rate.
        push_expected(0, 2, 8);
        drive_start(0, 2, 8);
        run_to_done(40, 1'b0, cyc, fv);
        check("A_first_valid", fv, 3);
        check("A_done_cycle", cyc, 19);
        check("A_sb_empty", sb.size(), 0);
        check("A_idle_busy", busy, 0);
        @(posedge clk);
        #1;
        check("A_done_pulse", done, 0);

        // Row address wraps past the end of the RAM.
        push_expected(254, 4, 1);
        drive_start(254, 4, 1);
        run_to_done(40, 1'b0, cyc, fv);
        check("B_first_valid", fv, 3);
        check("B_done_cycle", cyc, 7);
        check("B_sb_empty", sb.size(), 0);

        // Back-pressure pattern with clamped column count.
        b0 = beats;
        push_expected(5, 3, 12);
        drive_start(5, 3, 12);
        run_to_done(400, 1'b1, cyc, fv);
        strm.m_ready = 1'b1;
        check("C_first_valid", fv, 3);
        check("C_beats", beats - b0, 24);
        check("C_sb_empty", sb.size(), 0);

        // Empty requests finish at once.
        drive_start(9, 3, 0);
        run_to_done(10, 1'b0, cyc, fv);
        check("D_cols0_cycle", cyc, 1);
        check("D_cols0_valid", fv, 0);
        drive_start(9, 0, 5);
        run_to_done(10, 1'b0, cyc, fv);
        check("D_rows0_cycle", cyc, 1);

        // A second start while busy must be ignored.
        push_expected(10, 1, 4);
        drive_start(10, 1, 4);
        base_addr = AW'(20);
        num_rows  = 9'd2;
        num_cols  = 4'd8;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("D_busy", busy, 1);
        run_to_done(40, 1'b0, cyc, fv);
        check("D_busy_done_cycle", cyc, 6);
        repeat (10) @(negedge clk);
        check("D_sb_empty", sb.size(), 0);
        check("D_idle", busy, 0);

        // Reset in the middle of a drain.
        b0 = beats;
        push_expected(0, 2, 8);
        drive_start(0, 2, 8);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (beats - b0 >= 5) break;
        end
        check("E_five_beats", beats - b0, 5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_zero("E_rst");
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            check("E_no_done", done, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        b0 = beats;
        push_expected(40, 1, 3);
        drive_start(40, 1, 3);
        run_to_done(40, 1'b0, cyc, fv);
        check("E_done_cycle", cyc, 6);
        check("E_beats", beats - b0, 3);
        check("E_sb_empty", sb.size(), 0);

        // Negative word passes through or clamps depending on the build.
        mem[2][77] = -32'sd5;
        push_expected(77, 1, 3);
        drive_start(77, 1, 3);
        run_to_done(40, 1'b0, cyc, fv);
        check("F_sb_empty", sb.size(), 0);

        @(negedge clk);
        check("idle_ram_idx", ram_idx, 0);
        check("idle_read_addr", read_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
